pulse_stretch_n: RTL and testbench
==================================

# pulse_stretch_n

Multi-channel, single-clock pulse stretcher for narrow or asynchronous strobes. Each of CHANNELS inputs is synchronized into `clk`, rising-edge detected, and turned into an output pulse exactly `len` cycles wide. A run-time mode selects how edges that arrive while a pulse is active are handled: ignore, retrigger, or queue with overflow reporting. It sits at the receiving side of clock-domain crossings and in front of slow consumers such as LED drivers and interrupt latches.

## Interface
- CHANNELS, 4, number of independent channels
- WIDTH, 4, width of the `len` stretch counter
- SYNC_STAGES, 2, synchronizer flops per input; 0 = input already in `clk` domain, no synchronizer
- QDEPTH, 3, maximum pending pulses per channel in QUEUE mode (at least 1)

- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- in  in  CHANNELS  raw input strobes, one bit per channel
- len  in  WIDTH  stretch length in `clk` cycles; 0 is treated as 1
- mode  in  2  0 = ONESHOT, 1 = RETRIGGER, 2 = QUEUE, 3 = reserved (behaves as ONESHOT)
- out  out  CHANNELS  stretched pulses, registered
- overflow  out  CHANNELS  1-cycle pulse when a QUEUE-mode edge is dropped, registered

## Operation
- Per channel: synchronizer chain, then `prev` flop; edge = sync_out & ~prev.
- Channel state is IDLE or ACTIVE. It holds a down-counter `cnt` (WIDTH bits) and a pending count `pend` (clog2(QDEPTH+1) bits).
- IDLE + edge: go ACTIVE, load `cnt` = max(`len`,1), `out`=1.
- ACTIVE: decrement `cnt` each cycle. `out` stays high for exactly the loaded count of cycles.
- `len` is sampled only at each load. Changing `len` mid-pulse does not affect the current pulse.
- Edge while ACTIVE, including on the last high cycle:
  - ONESHOT: edge is dropped silently.
  - RETRIGGER: reload `cnt` = max(`len`,1). `out` stays continuously high until `len` cycles after the last edge.
  - QUEUE: if `pend` < QDEPTH, increment `pend`. Otherwise drop the edge and pulse `overflow` for 1 cycle.
- End of pulse in QUEUE mode:
  - If `pend` > 0, `out` goes low for exactly 1 gap cycle, then a new pulse loads with the current `len` and `pend` decrements.
  - An edge arriving in the gap cycle is queued, not started immediately.
  - If `pend` = 0, return to IDLE.
- An edge in the same cycle `pend` is decremented: net `pend` is unchanged. This is not an overflow.
- `pend` clears whenever `mode` ≠ QUEUE. Mode is sampled every cycle, and switching mode mid-pulse does not truncate the current pulse.
- Channels are fully independent. There is no shared state except `len` and `mode`.
- Reset (asynchronous) forces all synchronizer flops, `prev`, `cnt`, `pend`, `out` and `overflow` to 0, and returns every channel to IDLE. Deassertion may occur mid-strobe. A level already high at deassertion produces one pulse after sync latency. This is the defined behaviour.

## Timing
- Edge-to-output latency: `out` rises on the (SYNC_STAGES+1)th rising `clk` edge that samples `in` high. With the default of 2 stages, that is 3 edges.
- Minimum detectable input: high across at least one rising `clk` edge. Narrower strobes must be stretched in their source domain first.
- Back-to-back input edges need at least one low sample between them to be detected as two edges.
- `overflow` is asserted in the cycle after the dropped edge is detected, i.e. aligned with when `out` would have reacted.
- Queued pulse spacing: `len` high, 1 low, `len` high, and so on.

## Structure
- `stretch_pkg.vh` holds localparams MODE_ONESHOT=0, MODE_RETRIGGER=1, MODE_QUEUE=2, STATE_IDLE, and STATE_ACTIVE. It is shared with the bench.
- Sub-module `stretch_chan` implements one channel: synchronizer, edge detect, FSM, `cnt`, `pend`, and its `out`/`overflow` bits.
- `pulse_stretch_n` is a generate loop over CHANNELS instantiating `stretch_chan`.

## Test plan
- Reset/latency:
  - Stimulus: `len`=3, ONESHOT, single 1-cycle strobe on ch0.
  - Response: `out[0]` high for exactly 3 cycles, starting 3 edges after first sample; other channels stay 0.
  - Also: assert `reset` mid-pulse; all outputs drop immediately.
- `len`=0:
  - Stimulus: single strobe.
  - Response: `out` high for exactly 1 cycle.
- ONESHOT vs RETRIGGER:
  - Stimulus: `len`=4, edges 2 cycles apart.
  - Response: ONESHOT gives one 4-cycle pulse. RETRIGGER gives one continuous 6-cycle pulse.
- QUEUE:
  - Stimulus: `len`=2, QDEPTH=3, 4 edges during the first pulse.
  - Response: `out` pattern 11 0 11 0 11 0 11, then low; no `overflow`.
  - Follow-up: a 5th edge during the first pulse produces exactly one 1-cycle `overflow` pulse.
- Boundary:
  - Stimulus: QUEUE, edge coincident with the last high cycle and another in the gap cycle.
  - Response: both are served as separate pulses.
  - Also: switch to ONESHOT with `pend`=2; `pend` clears and no further pulses follow.
- Channels/async:
  - Stimulus: all 4 channels with random jittered strobes, `clk` period 1.4 ns vs source period 2 ns.
  - Response: a scoreboard confirms per-channel pulse counts and widths match the model; no cross-channel interaction.

Source files
------------

// File: rtl/pulse_stretch_n_pkg.sv
// Shared mode encodings and channel state type for the pulse stretcher.
package pulse_stretch_n_pkg;

  localparam logic [1:0] MODE_ONESHOT   = 2'd0;
  localparam logic [1:0] MODE_RETRIGGER = 2'd1;
  localparam logic [1:0] MODE_QUEUE     = 2'd2;

  // GAP is the single low cycle separating queued pulses.
  typedef enum logic [1:0] {
    STATE_IDLE   = 2'd0,
    STATE_ACTIVE = 2'd1,
    STATE_GAP    = 2'd2
  } chan_state_e;

endpackage

// File: rtl/pulse_stretch_n_chan.sv
// One stretcher channel: input synchronizer, rising-edge detect and the
// pulse generator with its pending-pulse counter.
module stretch_chan
  import pulse_stretch_n_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int QDEPTH      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_in,
  input  logic [WIDTH-1:0] i_len,
  input  logic [1:0]       i_mode,
  output logic             o_out,
  output logic             o_overflow
);
  localparam int PW = $clog2(QDEPTH + 1);

  logic w_sync_out;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_sync <= '0;
        end else begin
          r_sync[0] <= i_in;
          for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
        end
      end
      assign w_sync_out = r_sync[SYNC_STAGES-1];
    end else begin : g_nosync
      assign w_sync_out = i_in;
    end
  endgenerate

  logic             r_prev;
  chan_state_e      r_state, w_state_next;
  logic [WIDTH-1:0] r_cnt, w_cnt_next;
  logic [PW-1:0]    r_pend, w_pend_next;
  logic             r_out, r_ovf;
  logic             w_edge, w_queue, w_q_edge, w_dec, w_accept, w_drop;
  logic [WIDTH-1:0] w_len_eff;

  assign w_edge    = w_sync_out & ~r_prev;
  assign w_len_eff = (i_len == '0) ? WIDTH'(1) : i_len;
  assign w_queue   = (i_mode == MODE_QUEUE);
  assign w_q_edge  = w_edge & w_queue & (r_state != STATE_IDLE);
  assign w_dec     = w_queue & (r_state == STATE_GAP);
  // The GAP->ACTIVE reload frees a slot in the same cycle, so a coincident edge still fits.
  assign w_accept  = w_q_edge & ((r_pend < PW'(QDEPTH)) | w_dec);
  assign w_drop    = w_q_edge & ~w_accept;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_pend_next  = '0;
    if (w_queue) w_pend_next = r_pend + PW'(w_accept) - PW'(w_dec);
    case (r_state)
      STATE_IDLE: begin
        if (w_edge) begin
          w_state_next = STATE_ACTIVE;
          w_cnt_next   = w_len_eff;
        end
      end
      STATE_ACTIVE: begin
        if (w_edge && (i_mode == MODE_RETRIGGER)) w_cnt_next = w_len_eff;
        else if (r_cnt > WIDTH'(1))               w_cnt_next = r_cnt - WIDTH'(1);
        else if (w_queue && ((r_pend != '0) || w_accept)) w_state_next = STATE_GAP;
        else                                      w_state_next = STATE_IDLE;
      end
      STATE_GAP: begin
        if (w_queue) begin
          w_state_next = STATE_ACTIVE;
          w_cnt_next   = w_len_eff;
        end else begin
          w_state_next = STATE_IDLE;
        end
      end
      default: w_state_next = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev  <= 1'b0;
      r_state <= STATE_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_out   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_prev  <= w_sync_out;
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_pend  <= w_pend_next;
      r_out   <= (w_state_next == STATE_ACTIVE);
      r_ovf   <= w_drop;
    end
  end

  assign o_out      = r_out;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/pulse_stretch_n.sv
// Multi-channel pulse stretcher: independent channels sharing only len and mode.
module pulse_stretch_n
  import pulse_stretch_n_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int QDEPTH      = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in,
  input  logic [WIDTH-1:0]    len,
  input  logic [1:0]          mode,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] overflow
);

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      stretch_chan #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .QDEPTH     (QDEPTH)
      ) u_chan (
        .clk       (clk),
        .reset     (reset),
        .i_in      (in[gi]),
        .i_len     (len),
        .i_mode    (mode),
        .o_out     (out[gi]),
        .o_overflow(overflow[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pulse_stretch_n.sv
// Directed per-cycle vector table for channel 0, reset corner cases, and a
// jittered multi-channel run checked by a pulse-count/width scoreboard.
`timescale 1ns/1ps
module tb_pulse_stretch_n;
  import pulse_stretch_n_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] dir_in;
  logic [3:0] async_in;
  logic [3:0] all_done;
  logic       async_go = 1'b0;
  logic       mon_en = 1'b0;
  logic [3:0] dut_in;
  logic [3:0] len;
  logic [1:0] mode;
  logic [3:0] out;
  logic [3:0] overflow;

  int errors = 0;
  int checks = 0;
  int sb_strobes[4];
  int sb_pulses[4];
  int run_len[4];

  assign dut_in = async_go ? async_in : dir_in;

  always #0.7 clk = ~clk;

  pulse_stretch_n #(
    .CHANNELS(4), .WIDTH(4), .SYNC_STAGES(2), .QDEPTH(3)
  ) dut (
    .clk(clk), .reset(reset), .in(dut_in), .len(len), .mode(mode),
    .out(out), .overflow(overflow)
  );

  typedef struct {
    string      name;
    int         row;
    logic       in_b;
    logic [3:0] len;
    logic [1:0] mode;
    logic       exp_out;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic char_bit(string s, int i);
    return (i < s.len()) && (s.getc(i) == 8'h31);
  endfunction

  // Rows beyond a string's length read as 0; len/mode switch from *_a to *_b at row sw.
  task automatic add_seq(string name, string in_s, string out_s, string ovf_s, int n,
                         int len_a, int len_b, int mode_a, int mode_b, int sw);
    for (int i = 0; i < n; i++) begin
      vec_t v;
      v.name    = name;
      v.row     = i;
      v.in_b    = char_bit(in_s, i);
      v.len     = (i < sw) ? 4'(len_a) : 4'(len_b);
      v.mode    = (i < sw) ? 2'(mode_a) : 2'(mode_b);
      v.exp_out = char_bit(out_s, i);
      v.exp_ovf = char_bit(ovf_s, i);
      vecs.push_back(v);
    end
  endtask

  // Jittered sources: strobes last at least one 2 ns source period, spaced well apart.
  for (genvar gi = 0; gi < 4; gi++) begin : g_src
    logic s = 1'b0;
    logic done = 1'b0;
    assign async_in[gi] = s;
    assign all_done[gi] = done;
    initial begin
      wait (async_go);
      #(0.3 * gi);
      for (int k = 0; k < 8; k++) begin
        #(2.0 * $urandom_range(7, 12) + $urandom_range(0, 600) / 1000.0);
        s = 1'b1;
        sb_strobes[gi]++;
        #(2.0 + $urandom_range(0, 300) / 1000.0);
        s = 1'b0;
      end
      done = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (mon_en) begin
      #0.2;
      if (overflow != 4'b0) check("async overflow", 32'(overflow), 32'd0);
      for (int c = 0; c < 4; c++) begin
        if (out[c]) begin
          run_len[c]++;
        end else if (run_len[c] != 0) begin
          check($sformatf("async ch%0d width", c), 32'(run_len[c]), 32'd3);
          sb_pulses[c]++;
          $display("async ch%0d pulse #%0d width=%0d", c, sb_pulses[c], run_len[c]);
          run_len[c] = 0;
        end
      end
    end
  end

  initial begin
    int first_high;
    int highs;
    int rises;
    int waited;
    logic prev_o;
    logic [3:0] others;

    dir_in = 4'b0;
    len    = 4'd3;
    mode   = MODE_ONESHOT;

    add_seq("len3_oneshot", "01", "0001110000", "", 10, 3, 3, 0, 0, 10);
    add_seq("len0", "01", "000100000", "", 9, 0, 0, 0, 0, 9);
    add_seq("oneshot_2apart", "0101", "00011110000", "", 11, 4, 4, 0, 0, 11);
    add_seq("retrigger_2apart", "0101", "000111111000", "", 12, 4, 4, 1, 1, 12);
    add_seq("queue_4edges", "01010101", "0001101101101100", "", 16, 2, 2, 2, 2, 16);
    add_seq("queue_overflow", "0101010101", "0001111111101111111101111111101111111100",
            "000000000001", 40, 8, 8, 2, 2, 40);
    add_seq("queue_last_cycle", "01001", "0001110111000", "", 13, 3, 3, 2, 2, 13);
    add_seq("queue_gap_edge", "010101", "0001110111011100", "", 16, 3, 3, 2, 2, 16);
    add_seq("mode_switch_pend2", "0101010", "00011111100000", "", 14, 6, 6, 2, 0, 8);
    add_seq("len_change_midpulse", "01", "000111110000", "", 12, 5, 1, 0, 0, 5);
    add_seq("reserved_mode3", "0101", "00011110000", "", 11, 4, 4, 3, 3, 11);

    repeat (3) @(negedge clk);
    check("reset out", 32'(out), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    $display("reset state out=%b overflow=%b", out, overflow);
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      dir_in = {3'b000, vecs[i].in_b};
      len    = vecs[i].len;
      mode   = vecs[i].mode;
      @(posedge clk);
      #0.2;
      $display("vec %s[%0d] in=%b len=%0d mode=%0d out=%b ovf=%b", vecs[i].name, vecs[i].row,
               vecs[i].in_b, vecs[i].len, vecs[i].mode, out, overflow);
      check($sformatf("%s[%0d] out", vecs[i].name, vecs[i].row), 32'(out),
            {31'b0, vecs[i].exp_out});
      check($sformatf("%s[%0d] overflow", vecs[i].name, vecs[i].row), 32'(overflow),
            {31'b0, vecs[i].exp_ovf});
    end

    // Reset asserted mid-pulse must clear outputs without waiting for a clock edge.
    @(negedge clk);
    dir_in = 4'b0001; len = 4'd8; mode = MODE_ONESHOT;
    @(negedge clk);
    dir_in = 4'b0000;
    repeat (4) @(negedge clk);
    check("pre-reset out", 32'(out), 32'd1);
    #0.3 reset = 1'b0;
    #0.1;
    check("async reset out", 32'(out), 32'd0);
    check("async reset overflow", 32'(overflow), 32'd0);
    $display("mid-pulse reset out=%b overflow=%b", out, overflow);

    // Level already high when reset deasserts gives exactly one pulse after sync latency.
    @(negedge clk);
    dir_in = 4'b0010; len = 4'd3;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    first_high = 0; highs = 0; rises = 0; prev_o = 1'b0; others = 4'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk);
      #0.2;
      if (out[1] && !prev_o) begin
        rises++;
        if (first_high == 0) first_high = cyc;
      end
      if (out[1]) highs++;
      prev_o = out[1];
      others |= out & 4'b1101;
    end
    check("deassert level first high edge", 32'(first_high), 32'd3);
    check("deassert level width", 32'(highs), 32'd3);
    check("deassert level pulse count", 32'(rises), 32'd1);
    check("deassert level other channels", 32'(others), 32'd0);
    $display("reset-release level: first=%0d width=%0d pulses=%0d", first_high, highs, rises);
    @(negedge clk);
    dir_in = 4'b0000;
    repeat (6) @(negedge clk);

    // Jittered multi-channel run.
    len = 4'd3; mode = MODE_ONESHOT;
    mon_en = 1'b1;
    async_go = 1'b1;
    waited = 0;
    while ((all_done != 4'hF) && (waited < 3000)) begin
      @(posedge clk);
      waited++;
    end
    check("async sources finished", 32'(all_done), 32'hF);
    repeat (20) @(posedge clk);
    #0.5;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("async ch%0d pulse count", c), 32'(sb_pulses[c]), 32'(sb_strobes[c]));
      $display("async ch%0d strobes=%0d pulses=%0d", c, sb_strobes[c], sb_pulses[c]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
